mac_share_sched: RTL

- Round-robin scheduler that shares one MULTADDSUB18X18 block, with its output register enabled, between NUM_REQ requesters.
- Each requester streams a multiply-accumulate burst: first beat loads C, later beats accumulate into the DSP output register, last beat closes the burst.
- The scheduler locks the DSP to one requester per burst, drives the DSP control pins, and returns the tagged 54-bit result.
- Sits between the hwtest stimulus engines and the DSP instance.

---
 rtl/mac_share_pkg.sv | 34 +++
 rtl/mac_rr_arb.sv | 22 ++
 rtl/mac_share_sched.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mac_share_pkg.sv
// Shared types, widths and the round-robin search helper for the MAC-sharing scheduler.
package mac_share_pkg;

  localparam int unsigned A_W     = 18;
  localparam int unsigned C_W     = 54;
  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic [1:0] {IDLE, BURST, DRAIN, RESP} state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of req at or after ptr, wrapping modulo n.
  function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                       input logic [IDX_W-1:0]   ptr,
                                       input logic [IDX_W:0]     n);
    rr_pick_t       pick;
    logic [IDX_W:0] idx;
    pick = '0;
    for (int unsigned i = 0; i < MAX_REQ; i++) begin
      idx = {1'b0, ptr} + (IDX_W+1)'(i);
      if (idx >= n) idx = idx - n;
      if (!pick.found && ((IDX_W+1)'(i) < n) && req[idx[IDX_W-1:0]]) begin
        pick.found = 1'b1;
        pick.idx   = idx[IDX_W-1:0];
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mac_rr_arb.sv
// Combinational round-robin grant over a request vector, starting the search at ptr.
module mac_rr_arb
  import mac_share_pkg::*;
#(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            gnt_valid_c,
  output logic [ID_W-1:0] gnt_id_c
);

  rr_pick_t pick;

  always_comb begin
    pick        = rr_next(MAX_REQ'(req), IDX_W'(ptr), (IDX_W+1)'(N));
    gnt_valid_c = pick.found;
    gnt_id_c    = ID_W'(pick.idx);
  end

endmodule

// File: rtl/mac_share_sched.sv
// Round-robin scheduler sharing one MULTADDSUB18X18 (output register enabled) between requesters.
// Optional burst idle timeout enabled by defining MAC_TIMEOUT_EN.
module mac_share_sched
  import mac_share_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DSP_LAT = 1,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ-1:0]         req_first,
  input  logic [NUM_REQ-1:0]         req_last,
  input  logic [NUM_REQ*A_W-1:0]     req_a,
  input  logic [NUM_REQ*A_W-1:0]     req_b,
  input  logic [NUM_REQ*C_W-1:0]     req_c,
  input  logic [NUM_REQ-1:0]         req_signed,
  input  logic [NUM_REQ-1:0]         req_sub,
  output logic [A_W-1:0]             dsp_a,
  output logic [A_W-1:0]             dsp_b,
  output logic [C_W-1:0]             dsp_c,
  output logic                       dsp_signed,
  output logic                       dsp_addsub,
  output logic                       dsp_loadc,
  output logic                       dsp_cin,
  output logic                       dsp_ceout,
  output logic                       dsp_rstout,
  input  logic [C_W-1:0]             dsp_z,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [$clog2(NUM_REQ)-1:0] res_id,
  output logic [C_W-1:0]             res_z,
  output logic                       res_err
);

  localparam int unsigned ID_W  = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(DSP_LAT + 1);

  if (NUM_REQ < 2 || NUM_REQ > MAX_REQ || DSP_LAT < 1 || TIMEOUT < 1) begin : g_param_check
    $error("mac_share_sched: parameter out of range");
  end

  state_t          state, state_d;
  logic [ID_W-1:0] owner, rr_ptr, gnt_id;
  logic [CNT_W-1:0] cnt;
  logic            gnt_valid, grant, accept, capture, timeout;
  logic            seen, err;
  logic            own_valid, own_first, own_last;

  logic [A_W-1:0]  a_arr [NUM_REQ];
  logic [A_W-1:0]  b_arr [NUM_REQ];
  logic [C_W-1:0]  c_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*A_W +: A_W];
    assign b_arr[g] = req_b[g*A_W +: A_W];
    assign c_arr[g] = req_c[g*C_W +: C_W];
  end

  // New bursts are only granted to requesters presenting a first beat.
  mac_rr_arb #(.N(NUM_REQ), .ID_W(ID_W)) u_arb (
    .req         (req_valid & req_first),
    .ptr         (rr_ptr),
    .gnt_valid_c (gnt_valid),
    .gnt_id_c    (gnt_id)
  );

  assign own_valid  = req_valid[owner];
  assign own_first  = req_first[owner];
  assign own_last   = req_last[owner];
  assign dsp_a      = a_arr[owner];
  assign dsp_b      = b_arr[owner];
  assign dsp_c      = c_arr[owner];
  assign dsp_signed = req_signed[owner];
  assign dsp_addsub = req_sub[owner];
  assign dsp_cin    = 1'b0;

`ifdef MAC_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
  logic [TO_W-1:0] idle_cnt;

  assign timeout = (state == BURST) && !own_valid && (idle_cnt == TO_W'(TIMEOUT - 1));

  // Consecutive owner-idle cycles inside a burst.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                           idle_cnt <= '0;
    else if (state != BURST || own_valid) idle_cnt <= '0;
    else                                 idle_cnt <= idle_cnt + TO_W'(1);
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d    = state;
    grant      = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    req_ready  = '0;
    res_valid  = 1'b0;
    dsp_ceout  = 1'b0;
    dsp_rstout = 1'b0;
    dsp_loadc  = 1'b0;
    unique case (state)
      IDLE: begin
        dsp_rstout = 1'b1;
        if (gnt_valid) begin
          grant   = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        req_ready[owner] = 1'b1;
        dsp_loadc        = own_first;
        if (own_valid) begin
          accept    = 1'b1;
          dsp_ceout = 1'b1;
          if (own_last) state_d = DRAIN;
        end else if (timeout) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (cnt == CNT_W'(1)) begin
          capture = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        res_valid = 1'b1;
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      owner   <= '0;
      rr_ptr  <= '0;
      cnt     <= '0;
      seen    <= 1'b0;
      err     <= 1'b0;
      res_z   <= '0;
      res_id  <= '0;
      res_err <= 1'b0;
    end else begin
      state <= state_d;
      if (grant) begin
        owner  <= gnt_id;
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
        seen   <= 1'b0;
        err    <= 1'b0;
      end
      // A first flag after the opening beat reloads C but marks the burst bad.
      if (accept) begin
        seen <= 1'b1;
        if (own_first && seen) err <= 1'b1;
      end
      if (timeout) err <= 1'b1;
      if (state == BURST && state_d == DRAIN) cnt <= CNT_W'(DSP_LAT);
      else if (state == DRAIN)                cnt <= cnt - CNT_W'(1);
      if (capture) begin
        res_z   <= dsp_z;
        res_id  <= owner;
        res_err <= err;
      end
      if (res_valid && res_ready) res_err <= 1'b0;
    end
  end

endmodule
